// File: rtl/sram_chain_reader.sv
// sram_chain_reader
// Walks one packet's linked chain of SRAM pages for a single output port.
// For each page it reads the data, ECC and jump-table entries, presents the
// page downstream under valid/ready, and then releases the page back to the
// null-page pool with a one-cycle rd_op pulse.

module sram_chain_reader #(
   parameter int ADDR_WIDTH = 11,
   parameter int JT_WIDTH   = 16,
   parameter int ECC_WIDTH  = 8,
   parameter int PORT_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [PORT_WIDTH-1:0] req_port,
   input  logic [ADDR_WIDTH-1:0] req_head,
   input  logic [ADDR_WIDTH-1:0] req_pages,
   output logic                  sram_rd_en,
   output logic [ADDR_WIDTH-1:0] sram_rd_addr,
   output logic                  jt_rd_en,
   output logic [ADDR_WIDTH-1:0] jt_rd_addr,
   input  logic [JT_WIDTH-1:0]   jt_dout,
   output logic                  ecc_rd_en,
   output logic [ADDR_WIDTH-1:0] ecc_rd_addr,
   input  logic [ECC_WIDTH-1:0]  ecc_dout,
   output logic                  page_valid,
   input  logic                  page_ready,
   output logic [ADDR_WIDTH-1:0] page_addr,
   output logic [ECC_WIDTH-1:0]  page_ecc,
   output logic                  page_last,
   output logic                  rd_op,
   output logic [PORT_WIDTH-1:0] rd_port,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] cur_ptr;
   logic [ADDR_WIDTH-1:0] next_ptr;
   logic [ADDR_WIDTH-1:0] remaining;
   logic [PORT_WIDTH-1:0] port_r;

   // Upper jump-table bits carry no pointer information and are deliberately dropped.
   logic jt_upper_unused;
   assign jt_upper_unused = ^jt_dout[JT_WIDTH-1:ADDR_WIDTH];

   // Handshake and status flags follow directly from the state register.
   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   // Chain-walk FSM; every downstream-facing output is a register so nothing glitches.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         cur_ptr      <= '0;
         next_ptr     <= '0;
         remaining    <= '0;
         port_r       <= '0;
         sram_rd_en   <= 1'b0;
         sram_rd_addr <= '0;
         jt_rd_en     <= 1'b0;
         jt_rd_addr   <= '0;
         ecc_rd_en    <= 1'b0;
         ecc_rd_addr  <= '0;
         page_valid   <= 1'b0;
         page_addr    <= '0;
         page_ecc     <= '0;
         page_last    <= 1'b0;
         rd_op        <= 1'b0;
         rd_port      <= '0;
         rd_addr      <= '0;
         done         <= 1'b0;
      end else begin
         sram_rd_en <= 1'b0;
         jt_rd_en   <= 1'b0;
         ecc_rd_en  <= 1'b0;
         rd_op      <= 1'b0;
         done       <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  port_r    <= req_port;
                  cur_ptr   <= req_head;
                  remaining <= req_pages;
                  if (req_pages == '0) begin
                     done <= 1'b1;
                  end else begin
                     sram_rd_en   <= 1'b1;
                     jt_rd_en     <= 1'b1;
                     ecc_rd_en    <= 1'b1;
                     sram_rd_addr <= req_head;
                     jt_rd_addr   <= req_head;
                     ecc_rd_addr  <= req_head;
                     state        <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               next_ptr   <= jt_dout[ADDR_WIDTH-1:0];
               page_ecc   <= ecc_dout;
               page_addr  <= cur_ptr;
               page_last  <= (remaining == ADDR_WIDTH'(1));
               page_valid <= 1'b1;
               state      <= OUT;
            end
            OUT: begin
               if (page_ready) begin
                  page_valid <= 1'b0;
                  rd_op      <= 1'b1;
                  rd_port    <= port_r;
                  rd_addr    <= cur_ptr;
                  if (remaining == ADDR_WIDTH'(1)) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     cur_ptr      <= next_ptr;
                     remaining    <= remaining - ADDR_WIDTH'(1);
                     sram_rd_en   <= 1'b1;
                     jt_rd_en     <= 1'b1;
                     ecc_rd_en    <= 1'b1;
                     sram_rd_addr <= next_ptr;
                     jt_rd_addr   <= next_ptr;
                     ecc_rd_addr  <= next_ptr;
                     state        <= ISSUE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_chain_reader.sv
// tb_sram_chain_reader
// Self-checking bench: a page/release scoreboard built by walking the chain in
// the bench's own memory arrays, a table of directed packets, hand-timed
// sequences for latency/backpressure/reset/busy cases, and randomized packets.

module tb_sram_chain_reader;

   localparam int AW = 11;
   localparam int JW = 16;
   localparam int EW = 8;
   localparam int PW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [PW-1:0] req_port;
   logic [AW-1:0] req_head;
   logic [AW-1:0] req_pages;
   logic          sram_rd_en;
   logic [AW-1:0] sram_rd_addr;
   logic          jt_rd_en;
   logic [AW-1:0] jt_rd_addr;
   logic [JW-1:0] jt_dout = '0;
   logic          ecc_rd_en;
   logic [AW-1:0] ecc_rd_addr;
   logic [EW-1:0] ecc_dout = '0;
   logic          page_valid;
   logic          page_ready;
   logic [AW-1:0] page_addr;
   logic [EW-1:0] page_ecc;
   logic          page_last;
   logic          rd_op;
   logic [PW-1:0] rd_port;
   logic [AW-1:0] rd_addr;
   logic          busy;
   logic          done;

   sram_chain_reader #(
      .ADDR_WIDTH(AW), .JT_WIDTH(JW), .ECC_WIDTH(EW), .PORT_WIDTH(PW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_port(req_port),
      .req_head(req_head), .req_pages(req_pages),
      .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
      .jt_rd_en(jt_rd_en), .jt_rd_addr(jt_rd_addr), .jt_dout(jt_dout),
      .ecc_rd_en(ecc_rd_en), .ecc_rd_addr(ecc_rd_addr), .ecc_dout(ecc_dout),
      .page_valid(page_valid), .page_ready(page_ready), .page_addr(page_addr),
      .page_ecc(page_ecc), .page_last(page_last),
      .rd_op(rd_op), .rd_port(rd_port), .rd_addr(rd_addr),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Bench-side page-state memories with one-cycle read latency.
   logic [JW-1:0] jt_mem  [2048];
   logic [EW-1:0] ecc_mem [2048];

   always @(posedge clk) begin
      if (jt_rd_en)  jt_dout  <= jt_mem[jt_rd_addr];
      if (ecc_rd_en) ecc_dout <= ecc_mem[ecc_rd_addr];
   end

   typedef struct {
      logic [AW-1:0] addr;
      logic [EW-1:0] ecc;
      logic          last;
   } page_t;

   typedef struct {
      logic [PW-1:0] port;
      logic [AW-1:0] addr;
   } rel_t;

   typedef struct {
      logic [PW-1:0] port;
      logic [AW-1:0] head;
      logic [AW-1:0] pages;
      int            exp_rels;
      logic [AW-1:0] exp_last_addr;
      logic [EW-1:0] exp_last_ecc;
   } vec_t;

   page_t         exp_pages[$];
   rel_t          exp_rels[$];
   int            n_checks = 0;
   int            n_fail = 0;
   int            done_seen = 0;
   int            done_exp = 0;
   int            rel_seen = 0;
   logic [AW-1:0] last_rel_addr = '0;
   logic [EW-1:0] last_ecc_seen = '0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic failNow(input string name);
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s at %0t", name, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: walk the chain in the bench memories and queue what must come out.
   task automatic modelPacket(input logic [PW-1:0] port, input logic [AW-1:0] head, input logic [AW-1:0] pages);
      logic [AW-1:0] p;
      page_t         pg;
      rel_t          rl;
      p = head;
      for (int k = 0; k < int'(pages); k++) begin
         pg.addr = p;
         pg.ecc  = ecc_mem[p];
         pg.last = (k == int'(pages) - 1);
         exp_pages.push_back(pg);
         rl.port = port;
         rl.addr = p;
         exp_rels.push_back(rl);
         p = jt_mem[p][AW-1:0];
      end
      done_exp++;
   endtask

   // Present a request and hold it until accepted; returns one cycle after acceptance.
   task automatic applyStimulus(input logic [PW-1:0] port, input logic [AW-1:0] head, input logic [AW-1:0] pages);
      logic acc;
      int   cyc;
      modelPacket(port, head, pages);
      req_valid = 1'b1;
      req_port  = port;
      req_head  = head;
      req_pages = pages;
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 300) begin
         acc = req_ready;
         step();
         cyc++;
      end
      req_valid = 1'b0;
      if (!acc) failNow("req_accept_timeout");
   endtask

   task automatic waitIdle(input int bound);
      int c;
      c = 0;
      while ((busy || exp_rels.size() != 0) && c < bound) begin
         step();
         c++;
      end
      if (c >= bound) failNow("idle_timeout");
      step();
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, "_flags"},
                  {24'd0, sram_rd_en, jt_rd_en, ecc_rd_en, page_valid, page_last, rd_op, busy, done}, 0);
      checkOutput({name, "_addrs"}, {sram_rd_addr, jt_rd_addr, ecc_rd_addr}, 0);
      checkOutput({name, "_page"}, {page_addr, page_ecc}, 0);
      checkOutput({name, "_rel"}, {rd_port, rd_addr}, 0);
      checkOutput({name, "_req_ready"}, req_ready, 1);
   endtask

   logic          prev_stall = 1'b0;
   logic [AW-1:0] prev_addr  = '0;
   logic [EW-1:0] prev_ecc   = '0;
   logic          prev_last  = 1'b0;

   // Scoreboard: compare every accepted page, release and read strobe with the model.
   always @(negedge clk) begin
      page_t pg;
      rel_t  rl;
      if (rst_n) begin
         if (prev_stall) begin
            checkOutput("stall_valid", page_valid, 1);
            checkOutput("stall_addr", page_addr, prev_addr);
            checkOutput("stall_ecc", page_ecc, prev_ecc);
            checkOutput("stall_last", page_last, prev_last);
         end
         if (page_valid && page_ready) begin
            if (exp_pages.size() == 0) begin
               failNow("page_unexpected");
            end else begin
               pg = exp_pages.pop_front();
               checkOutput("page_addr", page_addr, pg.addr);
               checkOutput("page_ecc", page_ecc, pg.ecc);
               checkOutput("page_last", page_last, pg.last);
            end
            last_ecc_seen = page_ecc;
         end
         if (rd_op) begin
            if (exp_rels.size() == 0) begin
               failNow("rd_op_unexpected");
            end else begin
               rl = exp_rels.pop_front();
               checkOutput("rd_port", rd_port, rl.port);
               checkOutput("rd_addr", rd_addr, rl.addr);
            end
            rel_seen++;
            last_rel_addr = rd_addr;
         end
         if (sram_rd_en) begin
            checkOutput("strobe_vs_valid", page_valid, 0);
            checkOutput("strobe_jt_en", jt_rd_en, 1);
            checkOutput("strobe_ecc_en", ecc_rd_en, 1);
            checkOutput("strobe_jt_addr", jt_rd_addr, sram_rd_addr);
            checkOutput("strobe_ecc_addr", ecc_rd_addr, sram_rd_addr);
            if (exp_pages.size() == 0) failNow("read_unexpected");
            else checkOutput("read_addr", sram_rd_addr, exp_pages[0].addr);
         end
         if (done) done_seen++;
      end
      prev_stall = rst_n && page_valid && !page_ready;
      prev_addr  = page_addr;
      prev_ecc   = page_ecc;
      prev_last  = page_last;
   end

   task automatic randomizeMem();
      for (int i = 0; i < 2048; i++) begin
         jt_mem[i]  = JW'($urandom);
         ecc_mem[i] = EW'($urandom);
      end
   endtask

   initial begin
      vec_t vecs[5];
      int   r0;
      int   d0;
      int   c;
      logic [AW-1:0] chain_exp[3];

      rst_n = 1'b0;
      req_valid = 1'b0;
      req_port = '0;
      req_head = '0;
      req_pages = '0;
      page_ready = 1'b0;

      randomizeMem();
      jt_mem[10]    = 16'hF800 | 16'd700;
      jt_mem[700]   = 16'd2047;
      jt_mem[2047]  = 16'hFFFF;
      ecc_mem[10]   = 8'h11;
      ecc_mem[700]  = 8'h22;
      ecc_mem[2047] = 8'h33;
      ecc_mem[5]    = 8'hA3;
      jt_mem[2000]  = 16'hA800;
      jt_mem[0]     = 16'd3;
      ecc_mem[2000] = 8'h66;
      ecc_mem[0]    = 8'h44;
      ecc_mem[3]    = 8'h55;
      jt_mem[100]   = 16'd200;
      jt_mem[200]   = 16'd300;
      jt_mem[300]   = 16'd400;

      vecs[0] = '{port: 4'd3,  head: 11'd5,    pages: 11'd1, exp_rels: 1, exp_last_addr: 11'd5,    exp_last_ecc: 8'hA3};
      vecs[1] = '{port: 4'd7,  head: 11'd10,   pages: 11'd3, exp_rels: 3, exp_last_addr: 11'd2047, exp_last_ecc: 8'h33};
      vecs[2] = '{port: 4'd2,  head: 11'd2000, pages: 11'd3, exp_rels: 3, exp_last_addr: 11'd3,    exp_last_ecc: 8'h55};
      vecs[3] = '{port: 4'd15, head: 11'd10,   pages: 11'd2, exp_rels: 2, exp_last_addr: 11'd700,  exp_last_ecc: 8'h22};
      vecs[4] = '{port: 4'd0,  head: 11'd0,    pages: 11'd0, exp_rels: 0, exp_last_addr: 11'd0,    exp_last_ecc: 8'h00};

      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      rst_n = 1'b1;
      step();

      $display("[TB] single-page latency");
      page_ready = 1'b1;
      applyStimulus(4'd9, 11'd5, 11'd1);
      checkOutput("c1_sram_en", sram_rd_en, 1);
      checkOutput("c1_sram_addr", sram_rd_addr, 5);
      checkOutput("c1_req_ready", req_ready, 0);
      checkOutput("c1_busy", busy, 1);
      step();
      checkOutput("c2_valid", page_valid, 0);
      checkOutput("c2_sram_en", sram_rd_en, 0);
      step();
      checkOutput("c3_valid", page_valid, 1);
      checkOutput("c3_addr", page_addr, 5);
      checkOutput("c3_ecc", page_ecc, 8'hA3);
      checkOutput("c3_last", page_last, 1);
      step();
      checkOutput("c4_rd_op", rd_op, 1);
      checkOutput("c4_rd_addr", rd_addr, 5);
      checkOutput("c4_rd_port", rd_port, 9);
      checkOutput("c4_done", done, 1);
      checkOutput("c4_valid", page_valid, 0);
      checkOutput("c4_req_ready", req_ready, 1);
      step();
      checkOutput("c5_rd_op", rd_op, 0);
      checkOutput("c5_done", done, 0);
      waitIdle(50);

      $display("[TB] three-page chain spacing");
      chain_exp[0] = 11'd10;
      chain_exp[1] = 11'd700;
      chain_exp[2] = 11'd2047;
      r0 = rel_seen;
      applyStimulus(4'd7, 11'd10, 11'd3);
      for (int k = 0; k < 3; k++) begin
         step();
         step();
         checkOutput("chain_valid", page_valid, 1);
         checkOutput("chain_addr", page_addr, chain_exp[k]);
         checkOutput("chain_last", page_last, (k == 2));
         step();
      end
      waitIdle(50);
      checkOutput("chain_rel_count", rel_seen - r0, 3);

      $display("[TB] directed table");
      foreach (vecs[i]) begin
         r0 = rel_seen;
         d0 = done_seen;
         page_ready = 1'b1;
         applyStimulus(vecs[i].port, vecs[i].head, vecs[i].pages);
         if (vecs[i].pages == '0) checkOutput("zero_req_ready", req_ready, 1);
         waitIdle(100);
         checkOutput("tbl_rel_count", rel_seen - r0, vecs[i].exp_rels);
         checkOutput("tbl_done_count", done_seen - d0, 1);
         if (vecs[i].exp_rels > 0) begin
            checkOutput("tbl_last_rel", last_rel_addr, vecs[i].exp_last_addr);
            checkOutput("tbl_last_ecc", last_ecc_seen, vecs[i].exp_last_ecc);
         end
      end

      $display("[TB] backpressure on page 700");
      page_ready = 1'b1;
      applyStimulus(4'd7, 11'd10, 11'd3);
      c = 0;
      while (!(page_valid && page_addr == 11'd700) && c < 20) begin
         step();
         c++;
      end
      if (c >= 20) failNow("stall_page_timeout");
      page_ready = 1'b0;
      r0 = rel_seen;
      repeat (20) begin
         checkOutput("stall_hold_addr", page_addr, 700);
         checkOutput("stall_hold_ecc", page_ecc, 8'h22);
         checkOutput("stall_no_rd_op", rd_op, 0);
         step();
      end
      page_ready = 1'b1;
      waitIdle(50);
      checkOutput("stall_rel_count", rel_seen - r0, 2);

      $display("[TB] reset mid-packet");
      applyStimulus(4'd4, 11'd100, 11'd4);
      repeat (4) step();
      checkOutput("pre_reset_busy", busy, 1);
      checkOutput("pre_reset_valid", page_valid, 0);
      rst_n = 1'b0;
      step();
      checkAllZero("mid_reset");
      rst_n = 1'b1;
      exp_pages.delete();
      exp_rels.delete();
      done_exp--;
      r0 = rel_seen;
      d0 = done_seen;
      repeat (12) step();
      checkOutput("post_reset_no_rel", rel_seen - r0, 0);
      checkOutput("post_reset_no_done", done_seen - d0, 0);
      applyStimulus(4'd1, 11'd5, 11'd1);
      waitIdle(50);
      checkOutput("post_reset_rel", last_rel_addr, 5);

      $display("[TB] request held while busy");
      r0 = rel_seen;
      applyStimulus(4'd1, 11'd10, 11'd2);
      applyStimulus(4'd2, 11'd2000, 11'd3);
      waitIdle(100);
      checkOutput("busy_req_rel_count", rel_seen - r0, 5);
      checkOutput("busy_req_last_rel", last_rel_addr, 3);

      $display("[TB] randomized packets");
      for (int n = 0; n < 40; n++) begin
         randomizeMem();
         page_ready = ($urandom_range(0, 1) != 0);
         applyStimulus(PW'($urandom), AW'($urandom), AW'($urandom_range(0, 6)));
         c = 0;
         while ((busy || exp_rels.size() != 0) && c < 500) begin
            page_ready = ($urandom_range(0, 3) != 0);
            step();
            c++;
         end
         if (c >= 500) failNow("random_timeout");
         page_ready = 1'b1;
         step();
      end

      step();
      checkOutput("final_done_count", done_seen, done_exp);
      checkOutput("final_pages_left", exp_pages.size(), 0);
      checkOutput("final_rels_left", exp_rels.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_chain_reader.md
Name: sram_chain_reader

Overview:
- Dequeue-side walker for one output port's packet stored as a linked chain of SRAM pages.
- Given a head page and a page count, it does the following per page:
  - Issues SRAM data, ECC and jump-table reads to the shared page-state block.
  - Presents each page with its ECC code downstream under valid/ready.
  - Releases each accepted page back to the null-page pool via rd_op/rd_port/rd_addr.
- Sits between the port scheduler (request side) and the page-state block / SRAM read path.

Parameters:
- ADDR_WIDTH, 11, page address width (2048 pages).
- JT_WIDTH, 16, jump-table entry width; bits [ADDR_WIDTH-1:0] hold the next-page pointer, upper bits ignored.
- ECC_WIDTH, 8, ECC code width per page.
- PORT_WIDTH, 4, port index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  new packet read request.
- req_ready  out  1  high only in IDLE.
- req_port  in  PORT_WIDTH  port owning the packet.
- req_head  in  ADDR_WIDTH  first page of chain.
- req_pages  in  ADDR_WIDTH  number of pages in chain.
- sram_rd_en  out  1  SRAM data read strobe.
- sram_rd_addr  out  ADDR_WIDTH  SRAM data page address.
- jt_rd_en  out  1  jump-table read strobe.
- jt_rd_addr  out  ADDR_WIDTH  jump-table read address.
- jt_dout  in  JT_WIDTH  jump-table data, valid 1 cycle after jt_rd_en.
- ecc_rd_en  out  1  ECC read strobe.
- ecc_rd_addr  out  ADDR_WIDTH  ECC read address.
- ecc_dout  in  ECC_WIDTH  ECC data, valid 1 cycle after ecc_rd_en.
- page_valid  out  1  page ready for downstream.
- page_ready  in  1  downstream accepts page.
- page_addr  out  ADDR_WIDTH  presented page.
- page_ecc  out  ECC_WIDTH  ECC code of presented page.
- page_last  out  1  presented page is final page of the packet.
- rd_op  out  1  one-cycle page-release pulse.
- rd_port  out  PORT_WIDTH  port of released page.
- rd_addr  out  ADDR_WIDTH  released page address.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at packet completion.

Behaviour:
- Reset:
  - Reset is synchronous, active-low on rst_n; clock is clk.
  - State goes to IDLE. All outputs are 0 except req_ready=1.
  - Internal cur_ptr, next_ptr, remaining and port registers are cleared.
  - Reset mid-packet abandons the chain: no rd_op is issued for unreleased pages, and no done pulse.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - On req_valid && req_ready, latch port, cur_ptr=req_head, remaining=req_pages.
  - If req_pages==0: stay in IDLE, pulse done next cycle, no reads and no rd_op.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - sram_rd_en=jt_rd_en=ecc_rd_en=1, all three addresses = cur_ptr.
  - Go to WAIT.
- WAIT (1 cycle):
  - Capture next_ptr = jt_dout[ADDR_WIDTH-1:0] and ecc_r = ecc_dout.
  - Go to OUT.
- OUT:
  - page_valid=1, page_addr=cur_ptr, page_ecc=ecc_r, page_last=(remaining==1).
  - Outputs are held stable while page_ready=0, for an unlimited stall.
  - On page_valid && page_ready (accept):
    - Next cycle: rd_op=1, rd_port=latched port, rd_addr=accepted page, for exactly 1 cycle.
    - If remaining==1: go to IDLE; done=1 in the same cycle as the final rd_op.
    - Else: cur_ptr<=next_ptr, remaining<=remaining-1, go to ISSUE.
- Throughput: 3 cycles/page with page_ready held high. First page_valid appears 3 cycles after request acceptance.
- Strobe rules:
  - rd_op never coincides with a read strobe for the same page.
  - At most one rd_op per page.
  - Total rd_op pulses per packet = req_pages.
- Pointer rules:
  - next_ptr is used verbatim; all addresses wrap modulo 2^ADDR_WIDTH with no range checks.
  - A chain ending at page 2047 or visiting page 0 is legal.
- Ignored jump-table data:
  - The jt pointer fetched for the last page is ignored, so garbage in that entry is harmless.
  - Upper jt bits [JT_WIDTH-1:ADDR_WIDTH] are ignored.
- Requests: req_valid while busy is not accepted (req_ready=0); the request must be held by the requester.
- Back-to-back packets: a new request can be accepted in the cycle after returning to IDLE. The final rd_op/done of the previous packet may overlap with the ISSUE of the next.

Test Plan:
- Single page: req_head=5, req_pages=1, ecc[5]=0xA3, page_ready=1 -> ISSUE at cycle 1, page_valid at cycle 3 with page_addr=5, page_ecc=0xA3, page_last=1; rd_op at cycle 4 with rd_addr=5 and rd_port=req_port; done at cycle 4.
- Chain 10->700->2047, req_pages=3, port 7 -> page_addr sequence 10, 700, 2047 spaced 3 cycles apart; page_last only on 2047; three rd_op pulses with rd_port=7.
- Backpressure: page_ready low for 20 cycles during OUT of page 700 -> page_valid/page_addr/page_ecc stable throughout; no rd_op until acceptance; no extra jt/sram reads issued.
- req_pages=0 -> no read strobes, no rd_op, done pulse once, req_ready stays 1.
- rst_n asserted low during WAIT of page 2 of a 4-page chain -> next cycle all outputs 0 and req_ready=1; no further rd_op; a new request afterwards runs normally.
- Request while busy: req_valid held during a 2-page packet -> accepted only after done; sequence of rd_addr values is correct for both packets with no interleaving.
